// File: rtl/vy_hakem.sv
// ---------------------------------------------------------------------------
// vy_hakem : arbiter that lets PORT_SAYISI L1 requesters share one narrow
// memory bus. A granted request moves a whole L1 block (BLOK_BIT wide) as
// BLOK_KELIME consecutive VERI_BIT beats. Reads are answered with the
// assembled block on a shared response bus; writes produce no response.
//
// Configuration macro:
//   VY_HAKEM_DONEN_ONCELIK_EN  defined   -> round-robin grant (search starts
//                                           one past the last granted port)
//                              undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk_i, rstn_i           clock, asynchronous active-low reset
//   l1_istek_adres_i        per-port byte address (port k at k*ADRES_BIT)
//   l1_istek_gecerli_i      per-port request valid
//   l1_istek_yaz_i          per-port write (1) / read (0)
//   l1_istek_veri_i         per-port write block (port k at k*BLOK_BIT)
//   l1_istek_hazir_o        per-port request accepted (one-hot or zero)
//   l1_veri_o               shared read-response block
//   l1_veri_gecerli_o       per-port read response valid
//   l1_veri_hazir_i         per-port response ready
//   mem_gecerli_o           memory beat valid
//   mem_adres_o             memory beat byte address
//   mem_yaz_veri_o          memory write word
//   mem_wstrb_o             byte strobes, all ones on write beats
//   mem_hazir_i             memory beat accepted
//   mem_oku_veri_i          memory read word
//   durum_o                 current FSM state (debug)
//
// Handshakes: every channel uses valid/ready. A transfer happens in the cycle
// where both are high; the valid side keeps its payload stable until then and
// never retracts valid before the transfer.
// ---------------------------------------------------------------------------
module vy_hakem #(
    parameter int PORT_SAYISI = 2,
    parameter int ADRES_BIT   = 32,
    parameter int VERI_BIT    = 32,
    parameter int BLOK_BIT    = 128
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [PORT_SAYISI*ADRES_BIT-1:0] l1_istek_adres_i,
    input  logic [PORT_SAYISI-1:0]         l1_istek_gecerli_i,
    input  logic [PORT_SAYISI-1:0]         l1_istek_yaz_i,
    input  logic [PORT_SAYISI*BLOK_BIT-1:0] l1_istek_veri_i,
    output logic [PORT_SAYISI-1:0]         l1_istek_hazir_o,
    output logic [BLOK_BIT-1:0]            l1_veri_o,
    output logic [PORT_SAYISI-1:0]         l1_veri_gecerli_o,
    input  logic [PORT_SAYISI-1:0]         l1_veri_hazir_i,
    output logic                           mem_gecerli_o,
    output logic [ADRES_BIT-1:0]           mem_adres_o,
    output logic [VERI_BIT-1:0]            mem_yaz_veri_o,
    output logic [VERI_BIT/8-1:0]          mem_wstrb_o,
    input  logic                           mem_hazir_i,
    input  logic [VERI_BIT-1:0]            mem_oku_veri_i,
    output logic [1:0]                     durum_o
);

    localparam int BLOK_KELIME = BLOK_BIT / VERI_BIT;
    localparam int SAY_W       = (BLOK_KELIME > 1) ? $clog2(BLOK_KELIME) : 1;
    localparam int IDX_W       = (PORT_SAYISI > 1) ? $clog2(PORT_SAYISI) : 1;
    localparam int HIZA        = $clog2(BLOK_BIT / 8);
    localparam int KELIME_BAYT = VERI_BIT / 8;
    // Clears the byte-offset-within-block bits of a request address.
    localparam logic [ADRES_BIT-1:0] HIZA_MASKE =
        ~((ADRES_BIT'(1) << HIZA) - ADRES_BIT'(1));

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        AKTAR = 2'd1,
        YANIT = 2'd2
    } durum_t;

    durum_t                r_durum;
    logic [IDX_W-1:0]      r_port;
    logic                  r_yaz;
    logic [ADRES_BIT-1:0]  r_taban;
    logic [SAY_W-1:0]      r_sayac;
    logic [BLOK_BIT-1:0]   r_blok;

    logic                  w_secim_var;
    logic [IDX_W-1:0]      w_secim;
    logic                  w_aktar;
    logic                  w_son_vuru;

`ifdef VY_HAKEM_DONEN_ONCELIK_EN
    logic [IDX_W-1:0]      r_isaretci;

    // Each requester gets a distance from the port after the pointer; the
    // closest requesting port wins, which gives the wrap-around search order.
    always_comb begin
        int w_mesafe;
        int w_en_iyi;
        w_secim_var = 1'b0;
        w_secim     = '0;
        w_mesafe    = 0;
        w_en_iyi    = PORT_SAYISI;
        for (int k = 0; k < PORT_SAYISI; k++) begin
            w_mesafe = k - int'(r_isaretci) - 1;
            if (w_mesafe < 0) w_mesafe = w_mesafe + PORT_SAYISI;
            if (l1_istek_gecerli_i[k] && (w_mesafe < w_en_iyi)) begin
                w_en_iyi    = w_mesafe;
                w_secim_var = 1'b1;
                w_secim     = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_isaretci <= IDX_W'(PORT_SAYISI - 1);
        end else if ((r_durum == BOSTA) && w_secim_var) begin
            r_isaretci <= w_secim;
        end
    end
`else
    // Scan from the top so the lowest requesting index is the last write.
    always_comb begin
        w_secim_var = 1'b0;
        w_secim     = '0;
        for (int k = PORT_SAYISI - 1; k >= 0; k--) begin
            if (l1_istek_gecerli_i[k]) begin
                w_secim_var = 1'b1;
                w_secim     = IDX_W'(k);
            end
        end
    end
`endif

    assign w_aktar    = (r_durum == AKTAR);
    assign w_son_vuru = (r_sayac == SAY_W'(BLOK_KELIME - 1));

    // Grants only happen from BOSTA, so the cycle that leaves AKTAR/YANIT
    // can never grant. Reset gates the grant so outputs are quiet in reset.
    always_comb begin
        l1_istek_hazir_o = '0;
        if (rstn_i && (r_durum == BOSTA) && w_secim_var) begin
            l1_istek_hazir_o = PORT_SAYISI'(1) << w_secim;
        end
    end

    always_comb begin
        mem_gecerli_o  = w_aktar;
        mem_adres_o    = '0;
        mem_yaz_veri_o = '0;
        mem_wstrb_o    = '0;
        if (w_aktar) begin
            mem_adres_o = r_taban + ADRES_BIT'(r_sayac) * ADRES_BIT'(KELIME_BAYT);
            if (r_yaz) begin
                mem_yaz_veri_o = r_blok[int'(r_sayac)*VERI_BIT +: VERI_BIT];
                mem_wstrb_o    = '1;
            end
        end
    end

    always_comb begin
        l1_veri_gecerli_o = '0;
        if (r_durum == YANIT) begin
            l1_veri_gecerli_o = PORT_SAYISI'(1) << r_port;
        end
    end

    assign l1_veri_o = r_blok;
    assign durum_o   = r_durum;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_durum <= BOSTA;
            r_port  <= '0;
            r_yaz   <= 1'b0;
            r_taban <= '0;
            r_sayac <= '0;
            r_blok  <= '0;
        end else begin
            case (r_durum)
                BOSTA: begin
                    if (w_secim_var) begin
                        r_port  <= w_secim;
                        r_yaz   <= l1_istek_yaz_i[w_secim];
                        r_taban <= l1_istek_adres_i[int'(w_secim)*ADRES_BIT +: ADRES_BIT]
                                   & HIZA_MASKE;
                        r_blok  <= l1_istek_veri_i[int'(w_secim)*BLOK_BIT +: BLOK_BIT];
                        r_sayac <= '0;
                        r_durum <= AKTAR;
                    end
                end
                AKTAR: begin
                    if (mem_hazir_i) begin
                        if (!r_yaz) begin
                            r_blok[int'(r_sayac)*VERI_BIT +: VERI_BIT] <= mem_oku_veri_i;
                        end
                        if (w_son_vuru) begin
                            r_sayac <= '0;
                            r_durum <= r_yaz ? BOSTA : YANIT;
                        end else begin
                            r_sayac <= r_sayac + SAY_W'(1);
                        end
                    end
                end
                YANIT: begin
                    if (l1_veri_hazir_i[r_port]) begin
                        r_durum <= BOSTA;
                    end
                end
                default: r_durum <= BOSTA;
            endcase
        end
    end

endmodule

// File: tb/tb_vy_hakem.sv
module tb_vy_hakem;
  localparam int P  = 2;
  localparam int AB = 32;
  localparam int VB = 32;
  localparam int BB = 128;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [P*AB-1:0] adres;
  logic [P-1:0]    gecerli;
  logic [P-1:0]    yaz_i;
  logic [P*BB-1:0] veri;
  logic [P-1:0]    hazir_o;
  logic [BB-1:0]   l1_veri;
  logic [P-1:0]    veri_gecerli;
  logic [P-1:0]    veri_hazir;
  logic            mem_gecerli;
  logic [AB-1:0]   mem_adres;
  logic [VB-1:0]   mem_wdata;
  logic [VB/8-1:0] mem_wstrb;
  logic            mem_hazir;
  logic [VB-1:0]   mem_rd;
  logic [1:0]      durum;

  vy_hakem #(.PORT_SAYISI(P), .ADRES_BIT(AB), .VERI_BIT(VB), .BLOK_BIT(BB)) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .l1_istek_adres_i  (adres),
    .l1_istek_gecerli_i(gecerli),
    .l1_istek_yaz_i    (yaz_i),
    .l1_istek_veri_i   (veri),
    .l1_istek_hazir_o  (hazir_o),
    .l1_veri_o         (l1_veri),
    .l1_veri_gecerli_o (veri_gecerli),
    .l1_veri_hazir_i   (veri_hazir),
    .mem_gecerli_o     (mem_gecerli),
    .mem_adres_o       (mem_adres),
    .mem_yaz_veri_o    (mem_wdata),
    .mem_wstrb_o       (mem_wstrb),
    .mem_hazir_i       (mem_hazir),
    .mem_oku_veri_i    (mem_rd),
    .durum_o           (durum)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  rd_w[4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [127:0] obs);
    logic [127:0] e;
    chk({tag, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'(1));
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, obs, e);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_mem_valid"}, 128'(mem_gecerli), 128'(0));
    chk({tag, "_resp_valid"}, 128'(veri_gecerli), 128'(0));
    chk({tag, "_state"}, 128'(durum), 128'(0));
  endtask

  // driver: one full transaction on a single port, expectations queued first
  task automatic txn(input int port, input bit yaz, input logic [31:0] adr,
                     input logic [127:0] blok, input int stall_beat, input int stall_n,
                     input int resp_wait, input bit rakip);
    logic [31:0] taban;
    taban = adr & 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(128'(taban + 32'(i * 4)));
      if (yaz) exp_q.push_back(128'(blok[i*32 +: 32]));
    end
    if (!yaz) exp_q.push_back({rd_w[3], rd_w[2], rd_w[1], rd_w[0]});

    @(negedge clk);
    gecerli[port]        = 1'b1;
    yaz_i[port]          = yaz;
    adres[port*32 +: 32] = adr;
    veri[port*128 +: 128] = blok;
    mem_hazir            = 1'b1;
    veri_hazir           = '1;
    #1;
    chk("grant", 128'(hazir_o), 128'(P'(1) << port));

    @(negedge clk);
    gecerli[port]         = 1'b0;
    adres[port*32 +: 32]  = '1;
    veri[port*128 +: 128] = '1;
    for (int i = 0; i < 4; i++) begin
      if (i == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          mem_hazir = 1'b0;
          mem_rd    = $urandom;
          #1;
          chk("stall_valid", 128'(mem_gecerli), 128'(1));
          chk("stall_addr", 128'(mem_adres), exp_q[0]);
          if (yaz) chk("stall_data", 128'(mem_wdata), exp_q[1]);
          chk("stall_wstrb", 128'(mem_wstrb), 128'(yaz ? 4'hF : 4'h0));
          @(negedge clk);
        end
      end
      mem_hazir = 1'b1;
      mem_rd    = rd_w[i];
      #1;
      chk("beat_valid", 128'(mem_gecerli), 128'(1));
      chk("beat_wstrb", 128'(mem_wstrb), 128'(yaz ? 4'hF : 4'h0));
      chk("beat_resp_idle", 128'(veri_gecerli), 128'(0));
      pop_chk("beat_addr", 128'(mem_adres));
      if (yaz) pop_chk("beat_data", 128'(mem_wdata));
      @(negedge clk);
    end

    if (!yaz) begin
      if (rakip) gecerli[port ^ 1] = 1'b1;
      for (int w = 0; w < resp_wait; w++) begin
        veri_hazir = '0;
        #1;
        chk("resp_hold_valid", 128'(veri_gecerli), 128'(P'(1) << port));
        chk("resp_hold_data", 128'(l1_veri), exp_q[0]);
        chk("resp_hold_nogrant", 128'(hazir_o), 128'(0));
        @(negedge clk);
      end
      veri_hazir = '1;
      #1;
      chk("resp_valid", 128'(veri_gecerli), 128'(P'(1) << port));
      chk("resp_nogrant", 128'(hazir_o), 128'(0));
      pop_chk("resp_data", 128'(l1_veri));
      @(negedge clk);
      if (rakip) gecerli[port ^ 1] = 1'b0;
    end
    #1;
    idle_chk("post_txn");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn       = 1'b0;
    adres      = '0;
    gecerli    = '0;
    yaz_i      = '0;
    veri       = '0;
    veri_hazir = '1;
    mem_hazir  = 1'b0;
    mem_rd     = '0;

    // reset state, with a request present to show grants are held off
    repeat (3) @(posedge clk);
    @(negedge clk);
    gecerli = 2'b01;
    #1;
    chk("rst_grant", 128'(hazir_o), 128'(0));
    chk("rst_l1_veri", 128'(l1_veri), 128'(0));
    chk("rst_wstrb", 128'(mem_wstrb), 128'(0));
    chk("rst_addr", 128'(mem_adres), 128'(0));
    idle_chk("rst");
    @(negedge clk);
    gecerli = '0;
    rstn    = 1'b1;

    // single read on port 0, full-speed memory
    rd_w[0] = 32'h11; rd_w[1] = 32'h22; rd_w[2] = 32'h33; rd_w[3] = 32'h44;
    txn(0, 1'b0, 32'h0000_1234, '0, -1, 0, 0, 1'b0);

    // write on port 1 with beat 2 stalled three cycles
    txn(1, 1'b1, 32'h0000_4008, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 2, 3, 0, 1'b0);

    // read response held four cycles while another port waits
    for (int i = 0; i < 4; i++) rd_w[i] = $urandom;
    txn(0, 1'b0, 32'h0000_8F0C, '0, -1, 0, 4, 1'b1);

    // random reads with random stalls
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 4; i++) rd_w[i] = $urandom;
      txn(n % 2, 1'b0, $urandom, '0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 2), 1'b0);
    end

    // reset during beat 2 of a read
    for (int i = 0; i < 4; i++) rd_w[i] = $urandom;
    @(negedge clk);
    gecerli[0] = 1'b1; yaz_i[0] = 1'b0; adres[31:0] = 32'h0000_2000; mem_hazir = 1'b1;
    #1;
    chk("abort_grant", 128'(hazir_o), 128'(2'b01));
    @(negedge clk);
    gecerli[0] = 1'b0; mem_rd = rd_w[0];
    @(negedge clk);
    mem_rd = rd_w[1];
    @(negedge clk);
    mem_hazir = 1'b0;
    #1;
    chk("abort_pre_valid", 128'(mem_gecerli), 128'(1));
    chk("abort_pre_addr", 128'(mem_adres), 128'(32'h0000_2008));
    rstn = 1'b0;
    #1;
    chk("abort_async_valid", 128'(mem_gecerli), 128'(0));
    chk("abort_l1_veri", 128'(l1_veri), 128'(0));
    idle_chk("abort_rst");
    @(negedge clk);
    rstn = 1'b1; mem_hazir = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      idle_chk("abort_no_stale");
    end
    for (int i = 0; i < 4; i++) rd_w[i] = $urandom;
    txn(1, 1'b0, 32'h0000_3010, '0, -1, 0, 0, 1'b0);

    // both ports requesting continuously
`ifdef VY_HAKEM_DONEN_ONCELIK_EN
    exp_q.push_back(128'(2'b01)); exp_q.push_back(128'(2'b10));
    exp_q.push_back(128'(2'b01)); exp_q.push_back(128'(2'b10));
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(128'(2'b01));
`endif
    @(negedge clk);
    gecerli = 2'b11; yaz_i = 2'b11; mem_hazir = 1'b1;
    adres = {32'h0000_5000, 32'h0000_6000};
    veri  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    begin
      int grants;
      int last;
      int cyc;
      grants = 0; last = -1; cyc = 0;
      while (grants < 4 && cyc < 40) begin
        #1;
        if (hazir_o != '0) begin
          pop_chk("arb_grant", 128'(hazir_o));
          if (last >= 0) chk("arb_gap", 128'(cyc - last), 128'(5));
          last = cyc;
          grants++;
        end
        @(negedge clk);
        cyc++;
      end
      chk("arb_grant_count", 128'(grants), 128'(4));
    end
    gecerli = '0;
    repeat (4) @(negedge clk);
    #1;
    idle_chk("arb_done");

    // random write on port 0
    txn(0, 1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom},
        $urandom_range(0, 3), $urandom_range(1, 3), 0, 1'b0);

    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vy_hakem.md
VY_HAKEM -- requirements
Module: vy_hakem

Interface
REQ-001 SHALL have parameter PORT_SAYISI, default 2, number of L1 requester ports (1..8).
REQ-002 SHALL have parameter ADRES_BIT, default 32, byte-address width.
REQ-003 SHALL have parameter VERI_BIT, default 32, memory-bus word width (multiple of 8).
REQ-004 SHALL have parameter BLOK_BIT, default 128, L1 block width; BLOK_KELIME = BLOK_BIT/VERI_BIT, a power of two >= 1.
REQ-005 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port l1_istek_adres_i  in  PORT_SAYISI*ADRES_BIT  per-port block address, port k at [k*ADRES_BIT +: ADRES_BIT].
REQ-008 SHALL have port l1_istek_gecerli_i  in  PORT_SAYISI  per-port request valid.
REQ-009 SHALL have port l1_istek_yaz_i  in  PORT_SAYISI  per-port write (1) / read (0).
REQ-010 SHALL have port l1_istek_veri_i  in  PORT_SAYISI*BLOK_BIT  per-port write block.
REQ-011 SHALL have port l1_istek_hazir_o  out  PORT_SAYISI  per-port request accepted.
REQ-012 SHALL have port l1_veri_o  out  BLOK_BIT  shared read-response block.
REQ-013 SHALL have port l1_veri_gecerli_o  out  PORT_SAYISI  per-port read response valid.
REQ-014 SHALL have port l1_veri_hazir_i  in  PORT_SAYISI  per-port response ready.
REQ-015 SHALL have ports mem_gecerli_o out 1, mem_adres_o out ADRES_BIT, mem_yaz_veri_o out VERI_BIT, mem_wstrb_o out VERI_BIT/8 (all ones on write beats, zero on read beats), mem_hazir_i in 1, mem_oku_veri_i in VERI_BIT.

Function
REQ-016 SHALL implement states BOSTA, AKTAR, YANIT.
REQ-017 In BOSTA with any l1_istek_gecerli_i set, SHALL grant one port k, assert l1_istek_hazir_o[k] for exactly that cycle, latch address (low log2(BLOK_BIT/8) bits cleared), yaz, write block, and k, then enter AKTAR.
REQ-018 l1_istek_hazir_o SHALL be one-hot or zero and zero outside BOSTA.
REQ-019 In AKTAR, SHALL drive mem_gecerli_o=1 with beat i address = base + i*(VERI_BIT/8), write word = block[i*VERI_BIT +: VERI_BIT]; outputs SHALL stay stable until mem_hazir_i.
REQ-020 Beat completes on mem_gecerli_o && mem_hazir_i; read beats SHALL capture mem_oku_veri_i into block word i that cycle; counter i SHALL increment, no idle cycle between beats.
REQ-021 After beat BLOK_KELIME-1: write -> BOSTA (no response); read -> YANIT.
REQ-022 In YANIT, SHALL assert l1_veri_gecerli_o[k] with l1_veri_o stable until l1_veri_hazir_i[k]; that cycle -> BOSTA.
REQ-023 New grant SHALL NOT occur in the cycle leaving AKTAR/YANIT; earliest next grant is the following BOSTA cycle.
REQ-024 Read latency with mem_hazir_i constantly 1 and l1_veri_hazir_i=1: accept at cycle 0, beats cycles 1..BLOK_KELIME, response cycle BLOK_KELIME+1.
REQ-025 Requests on non-granted ports SHALL be held pending (requester keeps gecerli) without loss.
REQ-026 mem_gecerli_o, l1_veri_gecerli_o SHALL be 0 in BOSTA.

Reset
REQ-027 rstn_i low SHALL immediately (asynchronously) force BOSTA, beat counter 0, all outputs and latched block 0, priority pointer to PORT_SAYISI-1.
REQ-028 Reset mid-AKTAR or mid-YANIT SHALL abandon the transaction; no response is produced after release.

Configuration
REQ-029 Macro VY_HAKEM_DONEN_ONCELIK_EN defined: round-robin; search starts at pointer+1 modulo PORT_SAYISI, pointer updates to k on each grant.
REQ-030 Macro undefined: fixed priority, lowest index wins; pointer logic absent.

Verification
REQ-031 Single read port 0, addr 0x0000_1234, BLOK_BIT=128, mem returns 0x11,0x22,0x33,0x44, hazir=1 -> beat addrs 0x1230,0x1234,0x1238,0x123C, l1_veri_o=0x00000044_00000033_00000022_00000011 at cycle 5.
REQ-032 Write port 1, block 0xDDDD_CCCC_BBBB_AAAA..., mem_hazir_i stalled 3 cycles on beat 2 -> beat 2 addr/data held stable, wstrb=0xF, no l1_veri_gecerli_o.
REQ-033 Ports 0 and 1 request continuously, macro defined -> grants alternate 0,1,0,1; macro undefined -> port 0 granted every time.
REQ-034 Read response with l1_veri_hazir_i held low 4 cycles -> l1_veri_gecerli_o[k] and l1_veri_o stable 5 cycles, no new grant meanwhile.
REQ-035 rstn_i low during beat 2 of read -> mem_gecerli_o 0 in same cycle; after release, new port-1 request granted and completes normally, no stale response.
